// File: rtl/preg_free_list.sv
// preg_free_list
// ----------------------------------------------------------------------------
// Circular free list of physical register tags for the rename stage.
// The tag at the speculative head is offered every cycle and is taken when
// rename asserts alloc_req. Retiring instructions advance the committed head,
// released tags are appended at the tail, and a flush rewinds the speculative
// head back to the committed head.
//
// Ports:
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   flush         pipeline flush, rewinds spec_head to the committed head
//   alloc_req     rename wants one tag this cycle
//   alloc_ready   a tag is available (spec_count != 0 and no flush)
//   alloc_tag     tag at the speculative head (valid with alloc_ready)
//   commit_valid  oldest speculative allocation retires
//   free_valid    a released tag is returned
//   free_tag      the released tag
//   spec_count    tags available for allocation (tail - spec_head)
//   err           sticky: [0] free overflow, [1] commit past spec head,
//                 [2] double free
//
// Optional feature (macro PREG_FREE_LIST_DUP_CHECK_EN): an in_list bitmap
// that rejects frees of tags already in the list or of reserved tags.
// ----------------------------------------------------------------------------
module preg_free_list #(
  parameter int DEPTH = 64,
  parameter int TAG_W = 6,
  parameter int RSVD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             commit_valid,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic [TAG_W:0]   spec_count,
  output logic [2:0]       err
);

  // Pointers carry one extra wrap bit so a full list (DEPTH entries) and an
  // empty list are distinguishable; all arithmetic is modulo 2*DEPTH.
  typedef logic [TAG_W:0] ptr_t;

  localparam ptr_t DEPTH_P   = ptr_t'(DEPTH);
  localparam ptr_t INIT_TAIL = ptr_t'(DEPTH - RSVD);
  localparam ptr_t ONE_P     = ptr_t'(1);

  logic [TAG_W-1:0] mem [DEPTH];
  ptr_t             spec_head;
  ptr_t             cmt_head;
  ptr_t             tail;
  ptr_t             cmt_next;
  ptr_t             occ;
  logic             alloc_fire;
  logic             commit_ok;
  logic             full;
  logic             dup;
  logic             free_ok;

  assign spec_count  = tail - spec_head;
  assign alloc_ready = (spec_count != '0) && !flush;
  assign alloc_tag   = mem[spec_head[TAG_W-1:0]];
  assign alloc_fire  = alloc_req && alloc_ready;

  // The committed head may never pass the speculative head.
  assign commit_ok   = commit_valid && (cmt_head != spec_head);
  assign cmt_next    = commit_ok ? cmt_head + ONE_P : cmt_head;

  // Capacity is measured from the committed head: speculatively allocated
  // tags can still be rewound into the list, so their slots stay reserved.
  assign occ         = tail - cmt_head;
  assign full        = (occ == DEPTH_P);
  assign free_ok     = free_valid && !full && !dup;

`ifdef PREG_FREE_LIST_DUP_CHECK_EN
  logic [DEPTH-1:0] in_list;
  logic [DEPTH-1:0] alloc_clr;
  logic [DEPTH-1:0] free_set;
  logic [DEPTH-1:0] rewind_mask;
  ptr_t             rewind_len;
  logic [TAG_W-1:0] ring_off;

  assign dup = in_list[free_tag] || (free_tag < TAG_W'(RSVD));

  // One-hot set/clear vectors, plus the set of tags handed back by a flush:
  // every ring slot from the post-commit head up to spec_head is marked.
  always_comb begin
    alloc_clr             = '0;
    free_set              = '0;
    rewind_mask           = '0;
    ring_off              = '0;
    rewind_len            = spec_head - cmt_next;
    alloc_clr[alloc_tag]  = alloc_fire;
    free_set[free_tag]    = free_ok;
    for (int i = 0; i < DEPTH; i++) begin
      ring_off = TAG_W'(i) - cmt_next[TAG_W-1:0];
      if (flush && ({1'b0, ring_off} < rewind_len)) begin
        rewind_mask[mem[i]] = 1'b1;
      end
    end
  end

  // Membership bitmap: reserved tags start outside the list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        in_list[i] <= (i >= RSVD);
      end
    end else begin
      in_list <= (in_list & ~alloc_clr) | free_set | rewind_mask;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Pointer, storage and error-flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < DEPTH - RSVD) ? TAG_W'(i + RSVD) : '0;
      end
      spec_head <= '0;
      cmt_head  <= '0;
      tail      <= INIT_TAIL;
      err       <= '0;
    end else begin
      cmt_head <= cmt_next;
      if (flush) begin
        spec_head <= cmt_next;
      end else if (alloc_fire) begin
        spec_head <= spec_head + ONE_P;
      end
      if (free_ok) begin
        mem[tail[TAG_W-1:0]] <= free_tag;
        tail                 <= tail + ONE_P;
      end
      err <= err | {free_valid && dup,
                    commit_valid && !commit_ok,
                    free_valid && full};
    end
  end

endmodule
